// File: rtl/edge_event_sched_pkg.sv
// ----------------------------------------------------------------------------
// edge_event_sched_pkg : shared types and round-robin pick helper | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package edge_event_sched_pkg;

  // Lines are indexed with c_IDX_W bits, so N_LINES may not exceed c_MAX_LINES.
  localparam int c_MAX_LINES = 32;
  localparam int c_IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic [c_IDX_W-1:0] line;
    logic               fall;
  } evt_t;

  function automatic logic [c_IDX_W-1:0] rr_pick(input logic [c_MAX_LINES-1:0] pending,
                                                 input logic [c_IDX_W-1:0]     ptr,
                                                 input int unsigned            n);
    logic [c_IDX_W-1:0] pick;
    logic               found;
    int unsigned        j;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < c_MAX_LINES; k++) begin
      if (k < n) begin
        j = (32'(ptr) + k) % n;
        if (!found && pending[j]) begin
          pick  = c_IDX_W'(j);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_event_rr_arb.sv
// ----------------------------------------------------------------------------
// edge_event_rr_arb : N-way round-robin arbiter (lowest index >= ptr, wrapping) | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module edge_event_rr_arb
  import edge_event_sched_pkg::*;
#(
  parameter int N_LINES = 4
) (
  input  logic [N_LINES-1:0] i_req,
  input  logic [c_IDX_W-1:0] i_ptr,
  output logic [N_LINES-1:0] o_gnt,
  output logic [c_IDX_W-1:0] o_idx
);

  logic [c_MAX_LINES-1:0] w_req_ext;

  assign w_req_ext = c_MAX_LINES'(i_req);
  assign o_idx     = rr_pick(w_req_ext, i_ptr, N_LINES);
  assign o_gnt     = (|i_req) ? (N_LINES'(1) << o_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/edge_event_sched.sv
// ----------------------------------------------------------------------------
// edge_event_sched : rise/fall edge detector with per-line pending queue and
// round-robin valid/ready delivery. Assertions enabled by EDGE_EVENT_SCHED_SVA_EN. | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module edge_event_sched
  import edge_event_sched_pkg::*;
#(
  parameter  int N_LINES = 4,
  parameter  int CNT_W   = 8,
  localparam int LINE_W  = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_LINES-1:0] sig_i,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [LINE_W-1:0]  evt_line,
  output logic               evt_fall,
  output logic [N_LINES-1:0] pend_o,
  output logic [N_LINES-1:0] ovf_o,
  output logic [CNT_W-1:0]   drop_cnt,
  input  logic               clr_ovf
);

  state_e             r_state, w_state_nxt;
  evt_t               r_evt, w_sel;
  logic               r_armed;
  logic [N_LINES-1:0] r_prev, r_pr, r_pf, r_age, r_ovf;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_IDX_W-1:0] r_rr_ptr, w_idx, w_ptr_nxt;
  logic [N_LINES-1:0] w_rise, w_fall, w_clr_r, w_clr_f, w_pr_keep, w_pf_keep;
  logic [N_LINES-1:0] w_drop, w_new_r, w_new_f, w_pr_nxt, w_pf_nxt, w_age_nxt;
  logic [N_LINES-1:0] w_pend, w_gnt, w_fall_pick;
  logic [CNT_W:0]     w_pop, w_sum;
  logic               w_xfer, w_load, w_unused_line;

  assign w_rise = (r_armed && enable) ? (sig_i & ~r_prev) : '0;
  assign w_fall = (r_armed && enable) ? (~sig_i & r_prev) : '0;
  assign w_xfer = (r_state == HOLD) && evt_ready;

  always_comb begin
    w_clr_r = '0;
    w_clr_f = '0;
    for (int i = 0; i < N_LINES; i++) begin
      w_clr_r[i] = w_xfer && !r_evt.fall && (r_evt.line == c_IDX_W'(i));
      w_clr_f[i] = w_xfer &&  r_evt.fall && (r_evt.line == c_IDX_W'(i));
    end
  end

  // A same-cycle clear frees the flag, so a coincident edge becomes the new event.
  assign w_pr_keep = r_pr & ~w_clr_r;
  assign w_pf_keep = r_pf & ~w_clr_f;
  assign w_drop    = (w_rise & w_pr_keep) | (w_fall & w_pf_keep);
  assign w_new_r   = w_rise & ~w_pr_keep;
  assign w_new_f   = w_fall & ~w_pf_keep;
  assign w_pr_nxt  = w_pr_keep | w_rise;
  assign w_pf_nxt  = w_pf_keep | w_fall;

  always_comb begin
    w_age_nxt = r_age;
    for (int i = 0; i < N_LINES; i++) begin
      if (w_new_r[i] && w_pf_keep[i])      w_age_nxt[i] = 1'b1;
      else if (w_new_f[i] && w_pr_keep[i]) w_age_nxt[i] = 1'b0;
    end
  end

  assign w_pend      = r_pr | r_pf;
  assign w_fall_pick = r_pf & (~r_pr | r_age);

  edge_event_rr_arb #(.N_LINES(N_LINES)) u_arb (
    .i_req (w_pend),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_sel.line = w_idx;
  assign w_sel.fall = |(w_gnt & w_fall_pick);
  assign w_ptr_nxt  = (w_idx == c_IDX_W'(N_LINES - 1)) ? '0 : (w_idx + c_IDX_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        if (|w_pend) begin
          w_state_nxt = HOLD;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (evt_ready) w_state_nxt = (|(w_pr_nxt | w_pf_nxt)) ? LOAD : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_LINES; i++) w_pop = w_pop + {{CNT_W{1'b0}}, w_drop[i]};
  end

  // Clear and new drops in the same cycle: the drop is still counted.
  assign w_sum     = (clr_ovf ? '0 : {1'b0, r_cnt}) + w_pop;
  assign w_cnt_nxt = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_evt    <= '0;
      r_armed  <= 1'b0;
      r_prev   <= '0;
      r_pr     <= '0;
      r_pf     <= '0;
      r_age    <= '0;
      r_ovf    <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      r_prev  <= sig_i;
      r_pr    <= w_pr_nxt;
      r_pf    <= w_pf_nxt;
      r_age   <= w_age_nxt;
      r_ovf   <= (clr_ovf ? '0 : r_ovf) | w_drop;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_evt    <= w_sel;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign evt_valid     = (r_state == HOLD);
  assign evt_line      = r_evt.line[LINE_W-1:0];
  assign evt_fall      = r_evt.fall;
  assign pend_o        = w_pend;
  assign ovf_o         = r_ovf;
  assign drop_cnt      = r_cnt;
  assign w_unused_line = &{1'b0, r_evt.line};

`ifdef EDGE_EVENT_SCHED_SVA_EN
  logic [N_LINES-1:0] r_fell_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fell_seen <= '0;
    else        r_fell_seen <= r_fell_seen | w_fall;
  end

  default clocking cb_sva @(posedge clk); endclocking
  default disable iff (!rst_n);

  a_hold_stable: assert property (evt_valid && !evt_ready |=> evt_valid && $stable(evt_line) && $stable(evt_fall));
  a_cnt_mono:    assert property (!clr_ovf |=> drop_cnt >= $past(drop_cnt));
  a_fall_src:    assert property (evt_valid && evt_fall |-> r_fell_seen[evt_line]);

  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_sva_rise
    a_rise_kept: assert property ($rose(sig_i[gi]) && r_armed && enable |=> r_pr[gi] || r_ovf[gi]);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_event_sched.sv
// ----------------------------------------------------------------------------
// tb_edge_event_sched : scoreboard bench for edge_event_sched (N_LINES=4, CNT_W=8) | Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_edge_event_sched;

  logic       clk = 1'b0;
  logic       rst_n, enable, evt_ready, clr_ovf;
  logic [3:0] sig_i;
  logic       evt_valid, evt_fall;
  logic [1:0] evt_line;
  logic [3:0] pend_o, ovf_o;
  logic [7:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  edge_event_sched #(.N_LINES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sig_i     (sig_i),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_line  (evt_line),
    .evt_fall  (evt_fall),
    .pend_o    (pend_o),
    .ovf_o     (ovf_o),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || evt_valid); i++) tick();
    check_val("drain_q", exp_q.size(), 0);
    check_val("drain_valid", {31'd0, evt_valid}, 0);
  endtask

  // Event code = line*2 + fall; each accepted transfer is seen at exactly one negedge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) check_val("evt_expected", exp_q.size(), 1);
      else                   check_val("evt", {29'd0, evt_line, evt_fall}, exp_q.pop_front());
    end
  end

  initial begin
    logic [1:0] held_line;
    logic       held_fall;

    rst_n = 1'b0; enable = 1'b1; evt_ready = 1'b1; clr_ovf = 1'b0; sig_i = 4'b0011;
    tick(2);
    check_val("rst_valid", {31'd0, evt_valid}, 0);
    check_val("rst_line",  {30'd0, evt_line}, 0);
    check_val("rst_fall",  {31'd0, evt_fall}, 0);
    check_val("rst_pend",  {28'd0, pend_o}, 0);
    check_val("rst_ovf",   {28'd0, ovf_o}, 0);
    check_val("rst_cnt",   {24'd0, drop_cnt}, 0);

    // 1: arming must not report the initial high levels
    rst_n = 1'b1;
    tick(5);
    check_val("arm_pend", {28'd0, pend_o}, 0);
    sig_i[0] = 1'b0; exp_q.push_back(0 * 2 + 1);
    drain();

    // 2: latency from sampled edge to valid
    sig_i[2] = 1'b1; exp_q.push_back(2 * 2 + 0);
    tick();
    check_val("lat_pend", {28'd0, pend_o}, 32'h4);
    check_val("lat_valid0", {31'd0, evt_valid}, 0);
    tick();
    check_val("lat_valid1", {31'd0, evt_valid}, 1);
    check_val("lat_line", {30'd0, evt_line}, 2);
    tick();
    check_val("lat_pend_clr", {28'd0, pend_o}, 0);
    drain();

    // 3: rise then fall on line1, consumer stalled
    enable = 1'b0; sig_i[1] = 1'b0; tick(); enable = 1'b1;
    evt_ready = 1'b0;
    sig_i[1] = 1'b1; exp_q.push_back(1 * 2 + 0); tick();
    sig_i[1] = 1'b0; exp_q.push_back(1 * 2 + 1); tick();
    held_line = evt_line; held_fall = evt_fall;
    check_val("hold_pend", {28'd0, pend_o}, 32'h2);
    for (int i = 0; i < 10; i++) begin
      check_val("hold_stable", {29'd0, evt_valid, evt_line}, {29'd0, 1'b1, held_line});
      check_val("hold_fall", {31'd0, evt_fall}, {31'd0, held_fall});
      tick();
    end
    evt_ready = 1'b1;
    drain();

    // 4: simultaneous rises then falls, round-robin from pointer 0
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    sig_i = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(6);
    drain();
    sig_i = 4'b0100;
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(7);
    drain();

    // 5: three rises on line2 while stalled -> two drops, then clear
    enable = 1'b0; sig_i[2] = 1'b0; tick();
    evt_ready = 1'b0;
    enable = 1'b1; sig_i[2] = 1'b1; exp_q.push_back(4); tick();
    for (int r = 0; r < 2; r++) begin
      enable = 1'b0; sig_i[2] = 1'b0; tick();
      enable = 1'b1; sig_i[2] = 1'b1; tick();
    end
    tick();
    check_val("drop_ovf",  {28'd0, ovf_o}, 32'h4);
    check_val("drop_cnt",  {24'd0, drop_cnt}, 2);
    check_val("drop_pend", {28'd0, pend_o}, 32'h4);
    evt_ready = 1'b1;
    drain();
    check_val("drop_pend_clr", {28'd0, pend_o}, 0);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check_val("clr_ovf",   {28'd0, ovf_o}, 0);
    check_val("clr_cnt",   {24'd0, drop_cnt}, 0);

    // clear coinciding with a new drop: the drop wins
    enable = 1'b0; sig_i[2] = 1'b0; tick();
    evt_ready = 1'b0;
    enable = 1'b1; sig_i[2] = 1'b1; exp_q.push_back(4); tick();
    enable = 1'b0; sig_i[2] = 1'b0; tick();
    enable = 1'b1; sig_i[2] = 1'b1; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check_val("clrdrop_ovf", {28'd0, ovf_o}, 32'h4);
    check_val("clrdrop_cnt", {24'd0, drop_cnt}, 1);
    evt_ready = 1'b1;
    drain();

    // 6: async reset while an event is held
    evt_ready = 1'b0;
    sig_i[0] = 1'b1; tick(3);
    check_val("pre_rst_valid", {31'd0, evt_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", {31'd0, evt_valid}, 0);
    check_val("async_rst_pend",  {28'd0, pend_o}, 0);
    check_val("async_rst_ovf",   {28'd0, ovf_o}, 0);
    tick();
    rst_n = 1'b1; evt_ready = 1'b1;
    tick(10);
    check_val("post_rst_pend",  {28'd0, pend_o}, 0);
    check_val("post_rst_valid", {31'd0, evt_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
